// File: rtl/filter_select_ctrl.sv
// Filter preview sequencer: buttons -> box index 0..NUM_FILTERS-1, arrow sprite placement, filter start/done handshake.
// Latency: select_out moves on the frame tick after a button edge; arrow outputs follow select_out one cycle later.
// Flow: one-cycle start pulse, then waits for filter_done_in (bounded by TIMEOUT_CYCLES); result held until back.
//
// Ports:
//   clk_in, rst_in                   clock, synchronous active-high reset
//   hcount_in, vcount_in             raster position, frame tick at (0, V_ACTIVE)
//   left/right/confirm/back_in       debounced button levels (rising edges are acted on)
//   filter_done_in                   completion from the filter engine
//   select_out, arrow_*_out          current box index and arrow sprite placement
//   filter_sel_out, filter_start_out filter index latched at confirm, start pulse
//   show_result_out, busy_out        result display active / handshake in progress
//   timeout_out                      sticky abort flag, cleared by next confirm
module filter_select_ctrl #(
    parameter int NUM_FILTERS    = 6,
    parameter int V_ACTIVE       = 768,
    parameter int ARROW_Y        = 334,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        confirm_in,
    input  logic        back_in,
    input  logic        filter_done_in,
    output logic [2:0]  select_out,
    output logic [10:0] arrow_x_out,
    output logic [9:0]  arrow_y_out,
    output logic        use_up_arrow_out,
    output logic [2:0]  filter_sel_out,
    output logic        filter_start_out,
    output logic        show_result_out,
    output logic        busy_out,
    output logic        timeout_out
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      SEL_LAST = 3'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {
        ST_BROWSE,
        ST_START,
        ST_WAIT_DONE,
        ST_SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       select_q, select_d;
    logic             pend_vld_q, pend_vld_d;
    logic             pend_up_q, pend_up_d;     // 1 = +1 step, 0 = -1 step
    logic [2:0]       filter_sel_q, filter_sel_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             left_q, right_q, confirm_q, back_q;
    logic [10:0]      arrow_x_q;
    logic             use_up_q;

    logic left_edge, right_edge, confirm_edge, back_edge, frame_tick;

    assign left_edge    = left_in    & ~left_q;
    assign right_edge   = right_in   & ~right_q;
    assign confirm_edge = confirm_in & ~confirm_q;
    assign back_edge    = back_in    & ~back_q;
    assign frame_tick   = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));

    // Boxes are laid out as two rows of three: top row uses the up arrow.
    function automatic logic [10:0] arrow_x_of(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd3, 3'd6: arrow_x_of = 11'd120;
            3'd1, 3'd4, 3'd7: arrow_x_of = 11'd460;
            default:          arrow_x_of = 11'd800;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        pend_vld_d   = pend_vld_q;
        pend_up_d    = pend_up_q;
        filter_sel_d = filter_sel_q;
        timeout_d    = timeout_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_BROWSE: begin
                if (confirm_edge) begin
                    // Confirm wins over any same-cycle move and drops a pending one.
                    filter_sel_d = select_q;
                    pend_vld_d   = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = ST_START;
                end else begin
                    if (frame_tick && pend_vld_q) begin
                        if (pend_up_q) begin
                            select_d = (select_q == SEL_LAST) ? 3'd0 : select_q + 3'd1;
                        end else begin
                            select_d = (select_q == 3'd0) ? SEL_LAST : select_q - 3'd1;
                        end
                        pend_vld_d = 1'b0;
                    end
                    // Only the first edge of a frame is kept; simultaneous
                    // left+right cancel out.
                    if (!pend_vld_q && (left_edge ^ right_edge)) begin
                        pend_vld_d = 1'b1;
                        pend_up_d  = right_edge;
                    end
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (filter_done_in) begin
                    state_d = ST_SHOW;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_BROWSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHOW: begin
                if (back_edge) begin
                    state_d = ST_BROWSE;
                end
            end
            default: state_d = ST_BROWSE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_BROWSE;
            select_q     <= 3'd0;
            pend_vld_q   <= 1'b0;
            pend_up_q    <= 1'b0;
            filter_sel_q <= 3'd0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
            arrow_x_q    <= 11'd120;
            use_up_q     <= 1'b1;
            // Load current levels so a button held through reset is not an edge.
            left_q       <= left_in;
            right_q      <= right_in;
            confirm_q    <= confirm_in;
            back_q       <= back_in;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            pend_vld_q   <= pend_vld_d;
            pend_up_q    <= pend_up_d;
            filter_sel_q <= filter_sel_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
            arrow_x_q    <= arrow_x_of(select_q);
            use_up_q     <= (select_q < 3'd3);
            left_q       <= left_in;
            right_q      <= right_in;
            confirm_q    <= confirm_in;
            back_q       <= back_in;
        end
    end

    assign select_out       = select_q;
    assign arrow_x_out      = arrow_x_q;
    assign arrow_y_out      = 10'(ARROW_Y);
    assign use_up_arrow_out = use_up_q;
    assign filter_sel_out   = filter_sel_q;
    assign filter_start_out = (state_q == ST_START);
    assign show_result_out  = (state_q == ST_SHOW);
    assign busy_out         = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
    assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_filter_select_ctrl.sv
// Bench for filter_select_ctrl: directed vector table, then random stimulus
// against a behavioural model of the selection/handshake rules.
module tb_filter_select_ctrl;

    localparam int N_FILT = 6;
    localparam int T_OUT  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        left_b, right_b, confirm_b, back_b, done;
    logic [2:0]  select_out, filter_sel_out;
    logic [10:0] arrow_x_out;
    logic [9:0]  arrow_y_out;
    logic        use_up_arrow_out, filter_start_out, show_result_out, busy_out, timeout_out;

    always #5 clk = ~clk;

    filter_select_ctrl #(
        .NUM_FILTERS(N_FILT), .V_ACTIVE(768), .ARROW_Y(334), .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .left_in(left_b), .right_in(right_b), .confirm_in(confirm_b), .back_in(back_b),
        .filter_done_in(done),
        .select_out(select_out), .arrow_x_out(arrow_x_out), .arrow_y_out(arrow_y_out),
        .use_up_arrow_out(use_up_arrow_out), .filter_sel_out(filter_sel_out),
        .filter_start_out(filter_start_out), .show_result_out(show_result_out),
        .busy_out(busy_out), .timeout_out(timeout_out)
    );

    logic [31:0] act_vec;
    assign act_vec = {select_out, arrow_x_out, arrow_y_out, use_up_arrow_out, filter_sel_out,
                      filter_start_out, show_result_out, busy_out, timeout_out};

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] pack(input int sel, input int ax, input logic up, input int fs,
                                         input logic st, input logic sh, input logic bz, input logic to);
        return {3'(sel), 11'(ax), 10'd334, up, 3'(fs), st, sh, bz, to};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got sel=%0d x=%0d y=%0d up=%0b fs=%0d st=%0b sh=%0b bz=%0b to=%0b (vec %h), expected vec %h",
                     name, act[31:29], act[28:18], act[17:8], act[7], act[6:4], act[3], act[2], act[1], act[0],
                     act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_BROWSE = 0, M_START = 1, M_WAIT = 2, M_SHOW = 3;
    int m_mode, m_sel, m_pend, m_fs, m_to, m_wait_cycles, m_arrow_src;
    logic m_pl, m_pr, m_pc, m_pb;

    task automatic model_step(input logic r, input logic [10:0] h, input logic [9:0] v,
                              input logic l, input logic rt, input logic c, input logic b, input logic d);
        logic tick, le, re, ce, be;
        int newp;
        if (r) begin
            m_mode = M_BROWSE; m_sel = 0; m_pend = 0; m_fs = 0; m_to = 0;
            m_wait_cycles = 0; m_arrow_src = 0;
        end else begin
            tick = (h == 0) && (v == 768);
            le = l && !m_pl; re = rt && !m_pr; ce = c && !m_pc; be = b && !m_pb;
            m_arrow_src = m_sel;
            case (m_mode)
                M_BROWSE: begin
                    if (ce) begin
                        m_fs = m_sel; m_pend = 0; m_to = 0; m_mode = M_START;
                    end else begin
                        newp = m_pend;
                        if (tick && m_pend != 0) begin
                            m_sel = (m_sel + m_pend + N_FILT) % N_FILT;
                            newp = 0;
                        end
                        if ((le != re) && m_pend == 0) newp = le ? -1 : 1;
                        m_pend = newp;
                    end
                end
                M_START: begin
                    m_wait_cycles = 0; m_mode = M_WAIT;
                end
                M_WAIT: begin
                    m_wait_cycles++;
                    if (d) m_mode = M_SHOW;
                    else if (m_wait_cycles == T_OUT) begin m_to = 1; m_mode = M_BROWSE; end
                end
                default: if (be) m_mode = M_BROWSE;
            endcase
        end
        m_pl = l; m_pr = rt; m_pc = c; m_pb = b;
    endtask

    function automatic logic [31:0] model_out();
        return pack(m_sel, 120 + 340 * (m_arrow_src % 3), m_arrow_src < 3, m_fs,
                    m_mode == M_START, m_mode == M_SHOW,
                    m_mode == M_START || m_mode == M_WAIT, m_to != 0);
    endfunction

    // Apply one cycle of inputs, advance the model alongside, sample after the edge.
    task automatic cycle(input logic r, input logic [10:0] h, input logic [9:0] v,
                         input logic l, input logic rt, input logic c, input logic b, input logic d);
        rst = r; hcount = h; vcount = v;
        left_b = l; right_b = rt; confirm_b = c; back_b = b; done = d;
        model_step(r, h, v, l, rt, c, b, d);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, tick, l, r, c, b, d;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic rs, input logic tk, input logic l, input logic r, input logic c,
                       input logic b, input logic d, input int sel, input int ax, input logic up,
                       input int fs, input logic st, input logic sh, input logic bz, input logic to);
        vec_t v;
        v.rst = rs; v.tick = tk; v.l = l; v.r = r; v.c = c; v.b = b; v.d = d;
        v.exp = pack(sel, ax, up, fs, st, sh, bz, to);
        tv.push_back(v);
    endtask

    initial begin
        rst = 1'b1; hcount = 11'd0; vcount = 10'd767;
        left_b = 0; right_b = 0; confirm_b = 0; back_b = 0; done = 0;
        m_pl = 0; m_pr = 0; m_pc = 0; m_pb = 0;
        m_mode = M_BROWSE; m_sel = 0; m_pend = 0; m_fs = 0; m_to = 0; m_wait_cycles = 0; m_arrow_src = 0;

        //   rst tk l r c b d   sel  x   up fs st sh bz to
        add(1, 0, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(1, 0, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(0, 0, 0,1,0,0,0,  0, 120, 1, 0, 0,0,0,0);   // right edge mid-frame
        add(0, 0, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  1, 120, 1, 0, 0,0,0,0);   // tick applies +1
        add(0, 0, 0,0,0,0,0,  1, 460, 1, 0, 0,0,0,0);   // arrow follows a cycle later
        add(0, 0, 1,0,0,0,0,  1, 460, 1, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  0, 460, 1, 0, 0,0,0,0);
        add(0, 0, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(0, 0, 1,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);   // left from 0
        add(0, 1, 0,0,0,0,0,  5, 120, 1, 0, 0,0,0,0);   // wraps to 5
        add(0, 0, 0,0,0,0,0,  5, 800, 0, 0, 0,0,0,0);
        for (int k = 0; k < 5; k++)                       // three right edges in one frame
            add(0, 0, 0,(k % 2 == 0),0,0,0, 5, 800, 0, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  0, 800, 0, 0, 0,0,0,0);   // single wrap step 5->0
        add(0, 0, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);   // extra edges were dropped
        add(0, 0, 1,1,0,0,0,  0, 120, 1, 0, 0,0,0,0);   // left+right together
        add(0, 0, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(0, 0, 1,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  5, 120, 1, 0, 0,0,0,0);
        add(0, 0, 1,0,0,0,0,  5, 800, 0, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  4, 800, 0, 0, 0,0,0,0);
        add(0, 0, 0,0,0,0,0,  4, 460, 0, 0, 0,0,0,0);
        add(0, 0, 0,0,1,0,0,  4, 460, 0, 4, 1,0,1,0);   // confirm -> START
        add(0, 0, 0,0,0,0,1,  4, 460, 0, 4, 0,0,1,0);   // done during START ignored
        for (int k = 0; k < 8; k++)
            add(0, 0, 0,0,0,0,0,  4, 460, 0, 4, 0,0,1,0);
        add(0, 0, 0,0,0,0,1,  4, 460, 0, 4, 0,1,0,0);   // done -> SHOW
        add(0, 0, 0,1,1,0,0,  4, 460, 0, 4, 0,1,0,0);   // right/confirm ignored in SHOW
        add(0, 1, 0,0,0,0,0,  4, 460, 0, 4, 0,1,0,0);
        add(0, 0, 0,0,0,1,0,  4, 460, 0, 4, 0,0,0,0);   // back -> BROWSE
        add(0, 1, 0,0,0,0,0,  4, 460, 0, 4, 0,0,0,0);
        add(0, 0, 0,0,1,0,0,  4, 460, 0, 4, 1,0,1,0);   // confirm, no done follows
        for (int k = 1; k <= 17; k++)
            add(0, 0, 0,0,0,0,0,  4, 460, 0, 4, 0,0, k <= 16, k == 17);
        add(0, 0, 0,0,1,0,0,  4, 460, 0, 4, 1,0,1,0);   // confirm clears timeout
        add(0, 0, 0,0,0,0,0,  4, 460, 0, 4, 0,0,1,0);
        add(1, 0, 0,1,0,0,0,  0, 120, 1, 0, 0,0,0,0);   // reset in WAIT_DONE, right held
        add(0, 1, 0,1,0,0,1,  0, 120, 1, 0, 0,0,0,0);   // held right is no edge, done ignored
        add(0, 0, 0,0,0,0,1,  0, 120, 1, 0, 0,0,0,0);
        add(0, 1, 0,0,0,0,0,  0, 120, 1, 0, 0,0,0,0);

        foreach (tv[i]) begin
            cycle(tv[i].rst, 11'd0, tv[i].tick ? 10'd768 : 10'd767,
                  tv[i].l, tv[i].r, tv[i].c, tv[i].b, tv[i].d);
            check($sformatf("vec%0d", i), act_vec, tv[i].exp);
        end

        // ---------------- randomized phase against the model ----------------
        for (int n = 0; n < 4000; n++) begin
            logic rr, ll, rt, cc, bb, dd;
            ll = left_b; rt = right_b; cc = confirm_b; bb = back_b;
            if ($urandom_range(0, 3) == 0) ll = ~ll;
            if ($urandom_range(0, 3) == 0) rt = ~rt;
            if ($urandom_range(0, 5) == 0) cc = ~cc;
            if ($urandom_range(0, 3) == 0) bb = ~bb;
            dd = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 299) == 0);
            cycle(rr, 11'($urandom_range(0, 2)), 10'(766 + $urandom_range(0, 3)), ll, rt, cc, bb, dd);
            check($sformatf("rand%0d", n), act_vec, model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filter_select_ctrl.md
Name: filter_select_ctrl

Overview:
- Sequencing controller for the six-box filter preview screen.
- Turns left/right/confirm/back button levels into a selection index 0..5 and the matching arrow sprite placement.
- Selection updates only at the frame boundary, so the arrow never tears mid-frame.
- On confirm, runs a start/done handshake with the selected filter engine; on completion, holds the full-screen result state until back is pressed.

Parameters:
- NUM_FILTERS, 6, number of selectable boxes; index wraps in 0..NUM_FILTERS-1 (max 8).
- V_ACTIVE, 768, vcount value at which the frame tick fires (hcount_in==0 && vcount_in==V_ACTIVE).
- ARROW_Y, 334, arrow_y_out value for every index.
- TIMEOUT_CYCLES, 2_000_000, maximum WAIT_DONE dwell before abort.

Ports:
- clk_in  input  1  system/pixel clock
- rst_in  input  1  synchronous active-high reset
- hcount_in  input  11  current pixel column
- vcount_in  input  10  current pixel row
- left_in  input  1  debounced left button level
- right_in  input  1  debounced right button level
- confirm_in  input  1  debounced confirm button level
- back_in  input  1  debounced back button level
- filter_done_in  input  1  filter engine completion pulse/level
- select_out  output  3  current box index
- arrow_x_out  output  11  arrow sprite x
- arrow_y_out  output  10  arrow sprite y
- use_up_arrow_out  output  1  1 = up-arrow sprite, 0 = down-arrow sprite
- filter_sel_out  output  3  filter index latched at confirm
- filter_start_out  output  1  one-cycle start pulse to the filter engine
- show_result_out  output  1  1 while the filtered result is displayed full-screen
- busy_out  output  1  1 in START or WAIT_DONE
- timeout_out  output  1  sticky abort flag, cleared by the next confirm or by reset

Behaviour:
- Reset values:
  - select_out=0, arrow_x_out=120, arrow_y_out=ARROW_Y, use_up_arrow_out=1.
  - filter_sel_out=0, filter_start_out=0, show_result_out=0, busy_out=0, timeout_out=0.
  - state=BROWSE, pending move cleared.
  - Edge-detect registers load the current button levels, so a button held through reset does not produce an edge.
- Edge detection: rising edge = level high now, low in the previous cycle. All four buttons are registered.
- Pending move (BROWSE only):
  - A left or right edge sets pending = -1 or +1 if no move is already pending; further edges before the tick are dropped.
  - Left and right edges in the same cycle are both ignored.
- Frame tick (hcount_in==0 && vcount_in==V_ACTIVE):
  - If a move is pending, apply it and clear pending: +1 from NUM_FILTERS-1 wraps to 0; -1 from 0 wraps to NUM_FILTERS-1.
  - At most one step per frame.
- Arrow outputs: registered, updated in the cycle after select_out changes (1-cycle latency).
  - Index 0,1,2: use_up=1, x = 120, 460, 800.
  - Index 3,4,5: use_up=0, x = 120, 460, 800.
  - arrow_y_out is always ARROW_Y.
- State machine:
  - BROWSE:
    - A confirm edge latches filter_sel_out = select_out, discards any pending move, clears timeout_out, and goes to START.
    - If a confirm edge and a left/right edge arrive in the same cycle, confirm wins.
  - START:
    - filter_start_out=1 for exactly this one cycle.
    - Timeout counter cleared; go to WAIT_DONE.
  - WAIT_DONE:
    - filter_done_in=1 goes to SHOW.
    - If the counter reaches TIMEOUT_CYCLES-1 without done: set timeout_out and go to BROWSE.
    - filter_done_in arriving in the START cycle is ignored; only done in WAIT_DONE counts.
    - Buttons are ignored.
  - SHOW:
    - show_result_out=1.
    - A back edge goes to BROWSE with show_result_out=0 the next cycle.
    - left, right and confirm are ignored.
- select_out does not change outside BROWSE. It is retained across START, WAIT_DONE and SHOW.
- Reset mid-operation: the next cycle matches the reset values regardless of state. No start pulse is emitted after reset without a new confirm edge.

Test Plan:
- Reset, then one right edge mid-frame -> select_out stays 0 until the tick at (0,768), then 1 on the tick; the next cycle gives arrow_x_out=460, use_up=1.
- Three right edges within one frame, starting from index 5 -> after one tick select_out=0 (single wrap step), x=120, use_up=1. A left edge from 0 -> 5 after the tick, x=800, use_up=0.
- Left and right edges in the same cycle -> select_out unchanged after two ticks.
- At index 4, confirm edge -> filter_sel_out=4; filter_start_out high for exactly 1 cycle; busy_out=1. filter_done_in 10 cycles later -> show_result_out=1, busy_out=0. A right edge in SHOW has no effect. Back edge -> BROWSE, select_out still 4.
- With TIMEOUT_CYCLES=16 and no done -> timeout_out=1 and BROWSE after 16 WAIT_DONE cycles. The next confirm clears timeout_out and pulses start again.
- Assert rst_in during WAIT_DONE -> the next cycle shows all outputs at reset values. A later filter_done_in has no effect (state stays BROWSE).
